jtopl_wrctl: RTL
================

Name: jtopl_wrctl

Overview:
- Host-write scheduler for the OPL register file.
- Accepts CPU address-port and data-port writes, and decodes the OPL2 register index into a group, a subslot and an update strobe.
- Holds the selection and strobe stable long enough for the time-multiplexed slot rotation to reach the target and for the operator pipeline to absorb it.
- Keeps a per-channel F-number low-byte shadow, which it presents together with 0xB0-0xB8 writes.

Parameters:
- HOLD_CEN, 21: cen ticks the strobe stays asserted. That is 18 slots for one full rotation plus 3 pipeline stages.
- CNTW, 5: width of the hold counter. Must satisfy 2^CNTW > HOLD_CEN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cen  in  1  slot-advance clock enable, the same enable used by the register file
- cpu_din  in  8  host write data
- cpu_addr  in  1  0 = address port, 1 = data port
- cpu_we  in  1  host write strobe, one clk per write
- busy  out  1  high while a register update is being held
- wr_drop  out  1  one-clk pulse when a data write is rejected because busy is high
- reg_din  out  8  data presented to the register file
- reg_write  out  1  one-clk pulse when an update is accepted
- sel_group  out  2  target group, 0..2
- sel_sub  out  3  target subslot, 0..5
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon  out  1 each  update strobes, at most one high at a time
- latch_fnum  out  8  F-number low byte for the channel being updated

Behaviour:
- Reset values:
  - busy, wr_drop, reg_write and all up_* are 0.
  - reg_din, sel_group, sel_sub and latch_fnum are 0.
  - The address latch is 0x00 and all 9 fnum_lo entries are 0x00.
  - The state is IDLE and the counter is 0.
  - Reset asserted mid-HOLD aborts the update and produces the same values on the next clk.
- Address-port write (cpu_we=1, cpu_addr=0): the address latch takes cpu_din. This is accepted in every state and does not disturb an update in progress.
- Data-port decode uses the latched address A:
  - Operator ranges, off = A[4:0]. 0x20-0x35 drives up_mult, 0x40-0x55 up_ksl_tl, 0x60-0x75 up_ar_dr, 0x80-0x95 up_sl_rr.
    - Operator target: group = off[4:3], sub = off[2:0].
    - The target is valid only if off <= 0x15 and off[2:0] < 6, so offsets 0x06, 0x07, 0x0E and 0x0F are invalid.
  - Channel ranges, c = A[3:0], valid when c <= 8.
    - 0xA0-0xA8: fnum_lo[c] <= cpu_din on the next clk. Accepted in every state. No busy, no strobe.
    - 0xB0-0xB8 drives up_fnum and 0xC0-0xC8 drives up_fbcon.
    - Channel target: group = c/3, sub = c%3.
  - Any other or invalid address: the write is ignored, with no busy, no wr_drop and no strobe.
- State machine:
  - IDLE with a valid strobe-type data write: at the next edge reg_din <= cpu_din, sel_* <= target, the matching up_* <= 1, and reg_write <= 1. For up_fnum only, latch_fnum <= fnum_lo[c]. The counter is cleared and the state becomes HOLD.
  - HOLD, first clk: reg_write <= 0, so it lasts exactly one clk. busy = (state == HOLD).
  - HOLD, counting: the counter increments on each cen.
  - HOLD, exit: when cen=1 and counter == HOLD_CEN-1, at that edge up_* <= 0, the state becomes IDLE and the counter clears. busy falls the same edge.
  - HOLD, any cen-1 cycle: sel_*, reg_din and latch_fnum are frozen.
- Concurrent writes:
  - A strobe-type data write while in HOLD is discarded: wr_drop = 1 for one clk and outputs are unchanged.
  - A write on the exit clk itself is also dropped; the host must observe busy = 0 first.
  - An A0-A8 write while in HOLD updates fnum_lo only. latch_fnum is unaffected because it was captured at acceptance.
- cen = 0 stalls the counter indefinitely. Address and A0-A8 writes are still accepted during the stall.

Test Plan:
- Reset, then write addr 0x20 and data 0x21:
  - One clk later: reg_write = 1 for 1 clk, sel_group = 0, sel_sub = 0, up_mult = 1, reg_din = 0x21, busy = 1.
  - up_mult falls after exactly 21 cen ticks with cen every clk.
- Write addr 0x4D (off 0x0D) and data 0x3F:
  - Required: sel_group = 1, sel_sub = 5, up_ksl_tl = 1.
  - Repeat with addr 0x46: invalid, so no busy, no strobe and no wr_drop.
- Write addr 0xA7 with data 0x81, then addr 0xB7 with data 0x32:
  - Required: sel_group = 2, sel_sub = 1, up_fnum = 1, latch_fnum = 0x81, reg_din = 0x32.
  - Writing addr 0xA7 with data 0x55 during HOLD leaves latch_fnum = 0x81.
- During a HOLD started by 0xC4 (group 1, sub 1, up_fbcon), write addr 0x60 and data 0xF0:
  - Required: wr_drop pulses 1 clk and up_ar_dr stays 0.
  - After busy falls, a retry is accepted with sel = 0/0.
- cen asserted every 4th clk:
  - busy stays high for 84 clk (±4) after acceptance.
  - Asserting rst at hold tick 10 forces busy = 0, up_* = 0 and sel_* = 0 the next clk.
- Address 0xBD, 0x08 or 0x01 followed by a data write: no response on any output.

Source files
------------

// File: rtl/jtopl_wrctl_if.sv
// Host-write bus between the CPU side and the OPL write scheduler.
//   cpu_din/cpu_addr/cpu_we : host write (cpu_addr 0 = address port, 1 = data port)
//   busy, wr_drop           : scheduler status back to the host
//   reg_din, reg_write      : data and accept pulse for the register file
//   sel_group, sel_sub      : target slot selection held during the update
//   up_*                    : one-hot update strobes
//   latch_fnum              : F-number low byte captured with 0xB0-0xB8 writes
interface jtopl_wrctl_if;
  logic [7:0] cpu_din;
  logic       cpu_addr;
  logic       cpu_we;
  logic       busy;
  logic       wr_drop;
  logic [7:0] reg_din;
  logic       reg_write;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_mult;
  logic       up_ksl_tl;
  logic       up_ar_dr;
  logic       up_sl_rr;
  logic       up_fnum;
  logic       up_fbcon;
  logic [7:0] latch_fnum;

  modport master (
    output cpu_din, cpu_addr, cpu_we,
    input  busy, wr_drop, reg_din, reg_write, sel_group, sel_sub,
    input  up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon, latch_fnum
  );

  modport slave (
    input  cpu_din, cpu_addr, cpu_we,
    output busy, wr_drop, reg_din, reg_write, sel_group, sel_sub,
    output up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon, latch_fnum
  );
endinterface

// File: rtl/jtopl_wrctl.sv
// Host-write scheduler for the OPL register file.
// Latches the address port, decodes data-port writes into group/subslot/strobe and holds
// them for HOLD_CEN cen ticks so the slot rotation reaches the target and the operator
// pipeline absorbs it. Keeps a per-channel F-number low-byte shadow (0xA0-0xA8).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   cen      : slot-advance enable shared with the register file
//   bus      : host write inputs and scheduler outputs (see jtopl_wrctl_if)
module jtopl_wrctl #(
  parameter int unsigned HOLD_CEN = 21,  // 18-slot rotation plus 3 pipeline stages
  parameter int unsigned CNTW     = 5    // 2**CNTW must exceed HOLD_CEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  jtopl_wrctl_if.slave  bus
);

  typedef enum logic {StIdle, StHold} state_e;

  localparam logic [CNTW-1:0] CntLast = CNTW'(HOLD_CEN - 1);

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [7:0]      addr_q;
  logic [7:0]      fnum_lo_q [9];
  logic [7:0]      reg_din_q;
  logic [7:0]      latch_fnum_q;
  logic [1:0]      sel_group_q;
  logic [2:0]      sel_sub_q;
  logic [5:0]      up_q;         // {fbcon, fnum, sl_rr, ar_dr, ksl_tl, mult}
  logic            busy_q;
  logic            wr_drop_q;
  logic            reg_write_q;

  // Decode of the latched address
  logic [4:0] op_off;
  logic [3:0] chan;
  logic       op_ok;
  logic       ch_ok;
  logic [1:0] ch_group;
  logic [2:0] ch_sub;
  logic [5:0] strobe_v;
  logic [1:0] tgt_group;
  logic [2:0] tgt_sub;
  logic       fnum_lo_sel;
  logic       data_wr;
  logic       strobe_req;

  assign op_off = addr_q[4:0];
  assign chan   = addr_q[3:0];
  assign op_ok  = (op_off <= 5'h15) && (op_off[2:0] < 3'd6);
  assign ch_ok  = (chan <= 4'd8);

  always_comb begin
    ch_group = 2'd0;
    ch_sub   = 3'd0;
    case (chan)
      4'd1:    ch_sub = 3'd1;
      4'd2:    ch_sub = 3'd2;
      4'd3:    ch_group = 2'd1;
      4'd4:    begin ch_group = 2'd1; ch_sub = 3'd1; end
      4'd5:    begin ch_group = 2'd1; ch_sub = 3'd2; end
      4'd6:    ch_group = 2'd2;
      4'd7:    begin ch_group = 2'd2; ch_sub = 3'd1; end
      4'd8:    begin ch_group = 2'd2; ch_sub = 3'd2; end
      default: ;
    endcase
  end

  always_comb begin
    strobe_v    = 6'd0;
    tgt_group   = op_off[4:3];
    tgt_sub     = op_off[2:0];
    fnum_lo_sel = 1'b0;
    case (addr_q[7:4])
      4'h2, 4'h3: strobe_v[0] = op_ok && (addr_q[7:5] == 3'b001);
      4'h4, 4'h5: strobe_v[1] = op_ok;
      4'h6, 4'h7: strobe_v[2] = op_ok;
      4'h8, 4'h9: strobe_v[3] = op_ok;
      4'hA:       fnum_lo_sel = ch_ok;
      4'hB:       begin strobe_v[4] = ch_ok; tgt_group = ch_group; tgt_sub = ch_sub; end
      4'hC:       begin strobe_v[5] = ch_ok; tgt_group = ch_group; tgt_sub = ch_sub; end
      default:    ;
    endcase
  end

  assign data_wr    = bus.cpu_we && bus.cpu_addr;
  assign strobe_req = data_wr && (strobe_v != 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= 8'h00;
      for (int i = 0; i < 9; i++) fnum_lo_q[i] <= 8'h00;
      reg_din_q    <= 8'h00;
      latch_fnum_q <= 8'h00;
      sel_group_q  <= 2'd0;
      sel_sub_q    <= 3'd0;
      up_q         <= 6'd0;
      busy_q       <= 1'b0;
      wr_drop_q    <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      wr_drop_q   <= 1'b0;
      reg_write_q <= 1'b0;

      // Address and shadow writes are taken in any state
      if (bus.cpu_we && !bus.cpu_addr) addr_q <= bus.cpu_din;
      if (data_wr && fnum_lo_sel) fnum_lo_q[chan] <= bus.cpu_din;

      case (state_q)
        StIdle: begin
          if (strobe_req) begin
            reg_din_q   <= bus.cpu_din;
            sel_group_q <= tgt_group;
            sel_sub_q   <= tgt_sub;
            up_q        <= strobe_v;
            reg_write_q <= 1'b1;
            busy_q      <= 1'b1;
            if (strobe_v[4]) latch_fnum_q <= fnum_lo_q[chan];
            cnt_q       <= '0;
            state_q     <= StHold;
          end
        end
        StHold: begin
          // Includes the exit clk: the host must see busy low before retrying
          if (strobe_req) wr_drop_q <= 1'b1;
          if (cen) begin
            if (cnt_q == CntLast) begin
              up_q    <= 6'd0;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.wr_drop    = wr_drop_q;
  assign bus.reg_din    = reg_din_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.sel_group  = sel_group_q;
  assign bus.sel_sub    = sel_sub_q;
  assign bus.up_mult    = up_q[0];
  assign bus.up_ksl_tl  = up_q[1];
  assign bus.up_ar_dr   = up_q[2];
  assign bus.up_sl_rr   = up_q[3];
  assign bus.up_fnum    = up_q[4];
  assign bus.up_fbcon   = up_q[5];
  assign bus.latch_fnum = latch_fnum_q;

endmodule
